clock_time_ctrl: RTL and testbench

//  Sequencer for the six cascaded counter_0_9 BCD digits of the alarm clock (HH:MM:SS).

---
 rtl/clock_time_ctrl_if.sv | 26 ++
 rtl/clock_time_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_time_ctrl_if.sv
// Control-sequencer bus between the alarm-clock datapath (buttons, BCD digit counters) and clock_time_ctrl.
interface clock_time_ctrl_if;
  logic        tick_i;
  logic        btn_mode_i;
  logic        btn_inc_i;
  logic        btn_snooze_i;
  logic        btn_stop_i;
  logic        alarm_en_i;
  logic [23:0] digits_i;
  logic        up_o;
  logic [5:0]  enable_o;
  logic [5:0]  ld_o;
  logic [15:0] alm_disp_o;
  logic [2:0]  mode_o;
  logic        ring_o;

  modport slave (
    input  tick_i, btn_mode_i, btn_inc_i, btn_snooze_i, btn_stop_i, alarm_en_i, digits_i,
    output up_o, enable_o, ld_o, alm_disp_o, mode_o, ring_o
  );

  modport master (
    output tick_i, btn_mode_i, btn_inc_i, btn_snooze_i, btn_stop_i, alarm_en_i, digits_i,
    input  up_o, enable_o, ld_o, alm_disp_o, mode_o, ring_o
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// HH:MM:SS digit sequencer for the alarm clock: per-digit Enable/LD pulses, set-time/set-alarm
// mode FSM, alarm registers and ring/snooze FSM.
module clock_time_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned TMR_W       = 9
) (
  input logic              clk,
  input logic              rst_n,
  clock_time_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_RUN         = 3'd0,
    MODE_SET_HR      = 3'd1,
    MODE_SET_MIN     = 3'd2,
    MODE_SET_ALM_HR  = 3'd3,
    MODE_SET_ALM_MIN = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    RING_IDLE   = 2'd0,
    RING_ON     = 2'd1,
    RING_SNOOZE = 2'd2
  } ring_e;

  localparam logic [TMR_W-1:0] RING_LAST   = TMR_W'(RING_SECS - 1);
  localparam logic [TMR_W-1:0] SNOOZE_LAST = TMR_W'(SNOOZE_SECS - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};

  // BCD increment of a tens/units pair that wraps to 00 after tens_max:units_max.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] units,
                                         input logic [3:0] tens_max, input logic [3:0] units_max);
    logic [7:0] res;
    if ((tens == tens_max) && (units == units_max)) begin
      res = 8'h00;
    end else if (units == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, units + 4'd1};
    end
    return res;
  endfunction

  mode_e            mode_q;
  mode_e            mode_d;
  ring_e            ring_st_q;
  logic [TMR_W-1:0] tmr_q;
  logic [5:0]       enable_q, enable_d;
  logic [5:0]       ld_q, ld_d;
  logic [3:0]       alm_ht_q, alm_hu_q, alm_mt_q, alm_mu_q;
  logic             up_q, ring_q;
  logic             upd_p1_q, upd_p2_q;

  logic [3:0] su, st, mu, mt, hu, ht;
  logic       s_59, m_59, h_23;
  logic       run_tick, inc_evt, alarm_hit;

  assign {ht, hu, mt, mu, st, su} = bus.digits_i;

  // Decode the carry conditions and the events accepted this cycle.
  always_comb begin
    s_59      = (st == 4'd5) && (su == 4'd9);
    m_59      = (mt == 4'd5) && (mu == 4'd9);
    h_23      = (ht == 4'd2) && (hu == 4'd3);
    run_tick  = bus.tick_i && (mode_q == MODE_RUN) && !bus.btn_mode_i;
    inc_evt   = bus.btn_inc_i && !bus.btn_mode_i;
    // upd_p2_q marks the cycle in which the counters show the result of a RUN tick.
    alarm_hit = upd_p2_q && (mode_q == MODE_RUN) && bus.alarm_en_i &&
                ({ht, hu, mt, mu} == {alm_ht_q, alm_hu_q, alm_mt_q, alm_mu_q}) &&
                (st == 4'd0) && (su == 4'd0);
  end

  // Next mode on a Btn_Mode press.
  always_comb begin
    case (mode_q)
      MODE_RUN:         mode_d = MODE_SET_HR;
      MODE_SET_HR:      mode_d = MODE_SET_MIN;
      MODE_SET_MIN:     mode_d = MODE_SET_ALM_HR;
      MODE_SET_ALM_HR:  mode_d = MODE_SET_ALM_MIN;
      MODE_SET_ALM_MIN: mode_d = MODE_RUN;
      default:          mode_d = MODE_RUN;
    endcase
  end

  // Per-digit Enable/LD pattern for the event seen this cycle.
  always_comb begin
    enable_d = 6'b000000;
    ld_d     = 6'b000000;
    if (bus.btn_mode_i) begin
      if (mode_q == MODE_RUN) begin
        enable_d = 6'b000011;
        ld_d     = 6'b000011;
      end else begin
        enable_d = 6'b000000;
      end
    end else if (run_tick) begin
      if (s_59 && m_59 && h_23) begin
        enable_d = 6'b111111;
        ld_d     = 6'b111111;
      end else begin
        // Units digits wrap 9->0 on their own; tens at 5 and hour 23 need an explicit load.
        enable_d[0] = 1'b1;
        enable_d[1] = (su == 4'd9);
        ld_d[1]     = s_59;
        enable_d[2] = s_59;
        enable_d[3] = s_59 && (mu == 4'd9);
        ld_d[3]     = s_59 && m_59;
        enable_d[4] = s_59 && m_59;
        enable_d[5] = s_59 && m_59 && (hu == 4'd9);
      end
    end else if (inc_evt && (mode_q == MODE_SET_HR)) begin
      if (h_23) begin
        enable_d[5:4] = 2'b11;
        ld_d[5:4]     = 2'b11;
      end else begin
        enable_d[4] = 1'b1;
        enable_d[5] = (hu == 4'd9);
      end
    end else if (inc_evt && (mode_q == MODE_SET_MIN)) begin
      if (m_59) begin
        enable_d[3:2] = 2'b11;
        ld_d[3:2]     = 2'b11;
      end else begin
        enable_d[2] = 1'b1;
        enable_d[3] = (mu == 4'd9);
      end
    end else begin
      enable_d = 6'b000000;
    end
  end

  // Registered outputs, mode FSM, alarm registers and ring/snooze FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q  <= 6'b000000;
      ld_q      <= 6'b000000;
      up_q      <= 1'b1;
      mode_q    <= MODE_RUN;
      alm_ht_q  <= 4'd0;
      alm_hu_q  <= 4'd0;
      alm_mt_q  <= 4'd0;
      alm_mu_q  <= 4'd0;
      ring_st_q <= RING_IDLE;
      ring_q    <= 1'b0;
      tmr_q     <= TMR_ZERO;
      upd_p1_q  <= 1'b0;
      upd_p2_q  <= 1'b0;
    end else begin
      enable_q <= enable_d;
      ld_q     <= ld_d;
      up_q     <= 1'b1;
      upd_p1_q <= run_tick;
      upd_p2_q <= upd_p1_q;

      if (bus.btn_mode_i) begin
        mode_q <= mode_d;
      end else if (inc_evt && (mode_q == MODE_SET_ALM_HR)) begin
        {alm_ht_q, alm_hu_q} <= bcd_inc(alm_ht_q, alm_hu_q, 4'd2, 4'd3);
      end else if (inc_evt && (mode_q == MODE_SET_ALM_MIN)) begin
        {alm_mt_q, alm_mu_q} <= bcd_inc(alm_mt_q, alm_mu_q, 4'd5, 4'd9);
      end else begin
        mode_q <= mode_q;
      end

      case (ring_st_q)
        RING_IDLE: begin
          if (alarm_hit) begin
            ring_st_q <= RING_ON;
            tmr_q     <= TMR_ZERO;
            ring_q    <= 1'b1;
          end
        end
        RING_ON: begin
          if (!bus.alarm_en_i || bus.btn_stop_i) begin
            ring_st_q <= RING_IDLE;
            tmr_q     <= TMR_ZERO;
            ring_q    <= 1'b0;
          end else if (bus.btn_snooze_i) begin
            ring_st_q <= RING_SNOOZE;
            tmr_q     <= TMR_ZERO;
            ring_q    <= 1'b0;
          end else if (bus.tick_i) begin
            if (tmr_q == RING_LAST) begin
              ring_st_q <= RING_IDLE;
              tmr_q     <= TMR_ZERO;
              ring_q    <= 1'b0;
            end else begin
              tmr_q <= tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        RING_SNOOZE: begin
          if (!bus.alarm_en_i || bus.btn_stop_i) begin
            ring_st_q <= RING_IDLE;
            tmr_q     <= TMR_ZERO;
            ring_q    <= 1'b0;
          end else if (bus.tick_i) begin
            if (tmr_q == SNOOZE_LAST) begin
              ring_st_q <= RING_ON;
              tmr_q     <= TMR_ZERO;
              ring_q    <= 1'b1;
            end else begin
              tmr_q <= tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
          ring_st_q <= RING_IDLE;
          tmr_q     <= TMR_ZERO;
          ring_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable_o   = enable_q;
  assign bus.ld_o       = ld_q;
  assign bus.up_o       = up_q;
  assign bus.mode_o     = mode_q;
  assign bus.alm_disp_o = {alm_ht_q, alm_hu_q, alm_mt_q, alm_mu_q};
  assign bus.ring_o     = ring_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: BCD counters are modelled around the DUT and compared against a
// seconds-of-day / alarm / ring-state reference model driven by directed and random stimulus.
module tb_clock_time_ctrl;
  localparam int RING_SECS   = 60;
  localparam int SNOOZE_SECS = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_time_ctrl_if bus();

  clock_time_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS), .TMR_W(9)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Six counter_0_9 digits driven by the DUT's Enable/LD, with a bench-side preset path.
  logic [3:0]  cnt [6];
  logic        force_req = 1'b0;
  logic [23:0] force_val = 24'h0;
  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (force_req) cnt[i] <= force_val[4*i +: 4];
      else if (bus.enable_o[i]) cnt[i] <= bus.ld_o[i] ? 4'd0 : ((cnt[i] == 4'd9) ? 4'd0 : cnt[i] + 4'd1);
    end
  end
  assign bus.digits_i = {cnt[5], cnt[4], cnt[3], cnt[2], cnt[1], cnt[0]};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time of day in seconds, mode number, alarm hh/mm, ring state (0 idle, 1 ringing, 2 snooze).
  int m_secs = 0, m_mode = 0, m_ah = 0, m_am = 0, m_ring = 0, m_rcnt = 0;
  bit m_aen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] bcd_time(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [15:0] bcd_alm(input int h, input int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic model_step(input bit t, input bit m, input bit i, input bit sz, input bit sp);
    int h, mi;
    if (m_ring == 1) begin
      if (sp) m_ring = 0;
      else if (sz) begin m_ring = 2; m_rcnt = 0; end
      else if (t) begin m_rcnt++; if (m_rcnt == RING_SECS) m_ring = 0; end
    end else if (m_ring == 2) begin
      if (sp) m_ring = 0;
      else if (t) begin m_rcnt++; if (m_rcnt == SNOOZE_SECS) begin m_ring = 1; m_rcnt = 0; end end
    end
    h  = m_secs / 3600;
    mi = (m_secs / 60) % 60;
    if (m) begin
      if (m_mode == 0) m_secs = m_secs - (m_secs % 60);
      m_mode = (m_mode + 1) % 5;
    end else if (i) begin
      case (m_mode)
        1: m_secs = m_secs - h * 3600 + ((h + 1) % 24) * 3600;
        2: m_secs = m_secs - mi * 60 + ((mi + 1) % 60) * 60;
        3: m_ah = (m_ah + 1) % 24;
        4: m_am = (m_am + 1) % 60;
        default: ;
      endcase
    end else if (t && m_mode == 0) begin
      m_secs = (m_secs + 1) % 86400;
      if (m_aen && m_ring == 0 && m_secs == m_ah * 3600 + m_am * 60) begin
        m_ring = 1; m_rcnt = 0;
      end
    end
  endtask

  // One-cycle pulse on the chosen inputs; returns at the negedge of the following cycle.
  task automatic drive(input bit t, input bit m, input bit i, input bit sz, input bit sp);
    bus.tick_i = t; bus.btn_mode_i = m; bus.btn_inc_i = i; bus.btn_snooze_i = sz; bus.btn_stop_i = sp;
    model_step(t, m, i, sz, sp);
    @(negedge clk);
    bus.tick_i = 1'b0; bus.btn_mode_i = 1'b0; bus.btn_inc_i = 1'b0;
    bus.btn_snooze_i = 1'b0; bus.btn_stop_i = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic op(input bit t, input bit m, input bit i, input bit sz, input bit sp);
    drive(t, m, i, sz, sp);
    settle();
  endtask

  task automatic force_time(input int s);
    force_val = bcd_time(s);
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    m_secs = s;
  endtask

  task automatic set_aen(input bit b);
    bus.alarm_en_i = b;
    m_aen = b;
    if (!b) m_ring = 0;
    settle();
  endtask

  task automatic check_state();
    check_eq("digits", {8'h0, bus.digits_i}, {8'h0, bcd_time(m_secs)});
    check_eq("mode", {29'h0, bus.mode_o}, 32'(m_mode));
    check_eq("alm_disp", {16'h0, bus.alm_disp_o}, {16'h0, bcd_alm(m_ah, m_am)});
    check_eq("ring", {31'h0, bus.ring_o}, {31'h0, (m_ring == 1)});
  endtask

  initial begin
    bus.tick_i = 1'b0; bus.btn_mode_i = 1'b0; bus.btn_inc_i = 1'b0;
    bus.btn_snooze_i = 1'b0; bus.btn_stop_i = 1'b0; bus.alarm_en_i = 1'b0;
    force_req = 1'b1; force_val = 24'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_enable", {26'h0, bus.enable_o}, 32'h0);
    check_eq("rst_ld", {26'h0, bus.ld_o}, 32'h0);
    check_eq("rst_up", {31'h0, bus.up_o}, 32'h1);
    check_eq("rst_mode", {29'h0, bus.mode_o}, 32'h0);
    check_eq("rst_alm", {16'h0, bus.alm_disp_o}, 32'h0);
    check_eq("rst_ring", {31'h0, bus.ring_o}, 32'h0);
    rst_n = 1'b1; force_req = 1'b0;
    @(negedge clk);

    // Midnight rollover and a minute carry.
    force_time(23 * 3600 + 59 * 60 + 59);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("midnight_en", {26'h0, bus.enable_o}, 32'h3F);
    check_eq("midnight_ld", {26'h0, bus.ld_o}, 32'h3F);
    settle(); check_state();
    check_eq("midnight_digits", {8'h0, bus.digits_i}, 32'h000000);
    force_time(12 * 3600 + 34 * 60 + 59);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("carry_en", {26'h0, bus.enable_o}, 32'h07);
    check_eq("carry_ld", {26'h0, bus.ld_o}, 32'h02);
    settle(); check_state();
    check_eq("carry_digits", {8'h0, bus.digits_i}, 32'h123500);

    // Set-time modes.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("enter_sethr_ld", {26'h0, bus.ld_o}, 32'h03);
    check_eq("enter_sethr_en", {26'h0, bus.enable_o}, 32'h03);
    settle();
    op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    force_time(12 * 3600 + 59 * 60);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("setmin_ld32", {30'h0, bus.ld_o[3:2]}, 32'h3);
    check_eq("setmin_en54", {30'h0, bus.enable_o[5:4]}, 32'h0);
    settle(); check_state();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("set_tick_en", {26'h0, bus.enable_o}, 32'h0);
    settle(); check_state();

    // Alarm 07:30.
    op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (30) op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("alm_0730", {16'h0, bus.alm_disp_o}, 32'h0730);
    op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state();
    set_aen(1'b1);
    force_time(7 * 3600 + 29 * 60 + 59);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("ring_at_match", {31'h0, bus.ring_o}, 32'h0);
    @(negedge clk);
    check_eq("ring_after_match", {31'h0, bus.ring_o}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("snooze_ring", {31'h0, bus.ring_o}, 32'h0);
    settle();
    repeat (SNOOZE_SECS - 1) op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("snooze_hold", {31'h0, bus.ring_o}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("snooze_rering", {31'h0, bus.ring_o}, 32'h1);
    settle(); check_state();
    op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("stop_wins", {31'h0, bus.ring_o}, 32'h0);
    repeat (3) op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state();

    // Auto-stop after RING_SECS ticks.
    force_time(7 * 3600 + 29 * 60 + 59);
    op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ring_start", {31'h0, bus.ring_o}, 32'h1);
    repeat (RING_SECS - 1) op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ring_hold", {31'h0, bus.ring_o}, 32'h1);
    op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ring_timeout", {31'h0, bus.ring_o}, 32'h0);
    check_state();

    // Clr while in SET_ALM_HR.
    repeat (3) op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("mode_alm_hr", {29'h0, bus.mode_o}, 32'h3);
    rst_n = 1'b0;
    #1;
    check_eq("clr_mode", {29'h0, bus.mode_o}, 32'h0);
    check_eq("clr_alm", {16'h0, bus.alm_disp_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_mode = 0; m_ah = 0; m_am = 0; m_ring = 0; m_rcnt = 0;
    settle(); check_state();

    // Randomized operations.
    m_ah = 0; m_am = 0;
    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45) op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (r < 55) op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      else if (r < 70) op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else if (r < 73) op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      else if (r < 78) op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (r < 82) op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (r < 84) op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      else if (r < 87) set_aen(!m_aen);
      else if (r < 94) begin
        force_time(int'($urandom_range(0, 23)) * 3600 +
                   (($urandom_range(0, 1) == 1) ? 59 : int'($urandom_range(0, 59))) * 60 +
                   int'($urandom_range(55, 59)));
        settle();
      end else begin
        force_time((m_ah * 3600 + m_am * 60 + 86399) % 86400);
        settle();
      end
      check_state();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
